// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and comparator encodings, arbiter state type,
// and the illegal-opcode predicate used when a request is accepted.
package alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SLL    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLTU   = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_OP_MAX = 4'b1001;

    // {equal_inequal, Comparatorenable}
    localparam logic [1:0] CMP_OFF = 2'b00;
    localparam logic [1:0] CMP_EQ  = 2'b11;
    localparam logic [1:0] CMP_NE  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant: a lone requester wins outright, a tie goes to the priority holder.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        // NOTE: assign a default first so every path drives o_grant and no latch is inferred.
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute pipe (req 0) and the
// branch/address unit (req 1); one operation in flight, round-robin on ties.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [7:0]          req_op,
    input  logic [3:0]          req_cmp,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_op,
    output logic [1:0]          alu_cmp,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero
);

    arb_state_e        r_state;
    logic              r_prio;
    logic              r_owner;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_op;
    logic [1:0]        r_alu_cmp;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_err;

    logic [1:0]        w_grant;
    logic              w_win;
    logic              w_accept;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [3:0]        w_sel_op;
    logic [1:0]        w_sel_cmp;

    rr_arb2 u_rr_arb2 (
        .i_valid (req_valid),
        .i_prio  (r_prio),
        .o_grant (w_grant)
    );

    assign w_win     = w_grant[1];
    assign w_accept  = |(req_valid & req_ready);
    assign w_sel_a   = w_win ? req_a[2*DATA_W-1 -: DATA_W] : req_a[DATA_W-1:0];
    assign w_sel_b   = w_win ? req_b[2*DATA_W-1 -: DATA_W] : req_b[DATA_W-1:0];
    assign w_sel_op  = w_win ? req_op[7:4]  : req_op[3:0];
    assign w_sel_cmp = w_win ? req_cmp[3:2] : req_cmp[1:0];

    // Grants are offered only while idle, so a new request can never overtake
    // a response the previous owner has not yet taken.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (r_state == IDLE) begin
            req_ready = w_grant;
        end
        if (r_state == RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_prio       <= PRIO_INIT;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= ALU_AND;
            r_alu_cmp    <= CMP_OFF;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= w_sel_a;
                        r_alu_b   <= w_sel_b;
                        r_alu_op  <= w_sel_op;
                        r_alu_cmp <= w_sel_cmp;
                        r_owner   <= w_win;
                        r_rsp_err <= op_is_illegal(w_sel_op);
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                    r_state      <= RESP;
                end
                RESP: begin
                    // Priority moves only on a completed response, never on a dropped request.
                    if (rsp_ready[r_owner]) begin
                        r_prio  <= ~r_owner;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_cmp    = r_alu_cmp;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

endmodule
